// File: rtl/dcache_arb_pkg.sv
// ----------------------------------------------------------------------------
// dcache_arb_pkg
//   Shared types and constants for the data-cache arbiter.
//   - state_e : access sequencer states (idle, busy on the cache, done/ack)
//   - owner_e : which requester currently owns the cache port
//   - STARVE_LIMIT_DEFAULT : default number of consecutive pipeline grants
//     allowed while the debug port is waiting
// ----------------------------------------------------------------------------
package dcache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int STARVE_LIMIT_DEFAULT = 8;

endpackage : dcache_arb_pkg

// File: rtl/dcache_arbiter.sv
// ----------------------------------------------------------------------------
// dcache_arbiter
//   Shares one data-cache port between the pipeline writeback stage (P) and a
//   debug/DMA master (D). One access at a time: IDLE -> BUSY -> DONE -> IDLE,
//   so every access takes at least three cycles.
//
//   Configuration macro: DCACHE_ARB_RR_EN
//     undefined : fixed priority P over D, with a starvation counter that
//                 hands the port to D after STARVE_LIMIT consecutive P grants
//                 made while D was waiting.
//     defined   : round-robin; on simultaneous requests the port not granted
//                 last wins. STARVE_LIMIT is then unused.
//
//   Ports
//     clk_i, rst_i            : clock, synchronous active-high reset
//     p_req_i/p_we_i/p_adr_i/p_dat_i, p_dat_o/p_ack_o : pipeline requester
//     d_req_i/d_we_i/d_adr_i/d_dat_i, d_dat_o/d_ack_o : debug requester
//     c_stb_o/c_we_o/c_adr_o/c_dat_o, c_dat_i/c_ack_i : cache master side
//   All outputs are registered.
// ----------------------------------------------------------------------------
module dcache_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p_req_i,
  input  logic        p_we_i,
  input  logic [31:0] p_adr_i,
  input  logic [31:0] p_dat_i,
  output logic [31:0] p_dat_o,
  output logic        p_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        c_stb_o,
  output logic        c_we_o,
  output logic [31:0] c_adr_o,
  output logic [31:0] c_dat_o,
  input  logic [31:0] c_dat_i,
  input  logic        c_ack_i
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      winner;
  logic        c_stb_q, c_stb_d;
  logic        c_we_q, c_we_d;
  logic [31:0] c_adr_q, c_adr_d;
  logic [31:0] c_dat_q, c_dat_d;
  logic [31:0] p_dat_q, p_dat_d;
  logic [31:0] d_dat_q, d_dat_d;
  logic        p_ack_q, p_ack_d;
  logic        d_ack_q, d_ack_d;

`ifdef DCACHE_ARB_RR_EN
  // High when D should win the next tie, i.e. P was granted last.
  logic        prefer_d_q, prefer_d_d;

  function automatic owner_e pick_winner(input logic p_req, input logic d_req,
                                         input logic prefer_d);
    if (p_req && d_req) return prefer_d ? OWN_D : OWN_P;
    if (d_req)          return OWN_D;
    return OWN_P;
  endfunction

  assign winner = pick_winner(p_req_i, d_req_i, prefer_d_q);
`else
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve_cnt_q, starve_cnt_d;

  // D overrides P's fixed priority only once it has been starved LIMIT times.
  function automatic owner_e pick_winner(input logic p_req, input logic d_req,
                                         input logic starved);
    if (d_req && (!p_req || starved)) return OWN_D;
    return OWN_P;
  endfunction

  assign winner = pick_winner(p_req_i, d_req_i, starve_cnt_q == LIMIT);
`endif

  // Next-state logic: the cache-side request is latched on the grant and held
  // untouched through BUSY; cache acks outside BUSY fall through to defaults.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    c_stb_d = c_stb_q;
    c_we_d  = c_we_q;
    c_adr_d = c_adr_q;
    c_dat_d = c_dat_q;
    p_dat_d = p_dat_q;
    d_dat_d = d_dat_q;
    p_ack_d = 1'b0;
    d_ack_d = 1'b0;
`ifdef DCACHE_ARB_RR_EN
    prefer_d_d = prefer_d_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (p_req_i || d_req_i) begin
          state_d = ST_BUSY;
          owner_d = winner;
          c_stb_d = 1'b1;
          if (winner == OWN_D) begin
            c_we_d  = d_we_i;
            c_adr_d = d_adr_i;
            c_dat_d = d_dat_i;
          end else begin
            c_we_d  = p_we_i;
            c_adr_d = p_adr_i;
            c_dat_d = p_dat_i;
          end
`ifdef DCACHE_ARB_RR_EN
          prefer_d_d = (winner == OWN_P);
`else
          if (winner == OWN_D) begin
            starve_cnt_d = 8'd0;
          end else if (d_req_i && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
          end
`endif
        end
      end

      ST_BUSY: begin
        if (c_ack_i) begin
          state_d = ST_DONE;
          c_stb_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_dat_d = c_dat_i;
            d_ack_d = 1'b1;
          end else begin
            p_dat_d = c_dat_i;
            p_ack_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset also aborts any access in flight without an ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_P;
      c_stb_q <= 1'b0;
      c_we_q  <= 1'b0;
      c_adr_q <= 32'd0;
      c_dat_q <= 32'd0;
      p_dat_q <= 32'd0;
      d_dat_q <= 32'd0;
      p_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
`ifdef DCACHE_ARB_RR_EN
      prefer_d_q <= 1'b0;
`else
      starve_cnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      c_stb_q <= c_stb_d;
      c_we_q  <= c_we_d;
      c_adr_q <= c_adr_d;
      c_dat_q <= c_dat_d;
      p_dat_q <= p_dat_d;
      d_dat_q <= d_dat_d;
      p_ack_q <= p_ack_d;
      d_ack_q <= d_ack_d;
`ifdef DCACHE_ARB_RR_EN
      prefer_d_q <= prefer_d_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign c_stb_o = c_stb_q;
  assign c_we_o  = c_we_q;
  assign c_adr_o = c_adr_q;
  assign c_dat_o = c_dat_q;
  assign p_dat_o = p_dat_q;
  assign d_dat_o = d_dat_q;
  assign p_ack_o = p_ack_q;
  assign d_ack_o = d_ack_q;

endmodule : dcache_arbiter

// File: tb/tb_dcache_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dcache_arbiter
//   Directed, self-checking bench for dcache_arbiter (STARVE_LIMIT = 3).
//   Builds with or without DCACHE_ARB_RR_EN; the contention sequence picks
//   its expected grant order from the same macro.
// ----------------------------------------------------------------------------
module tb_dcache_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        p_req_i = 1'b0, p_we_i = 1'b0;
  logic [31:0] p_adr_i = '0, p_dat_i = '0;
  logic [31:0] p_dat_o;
  logic        p_ack_o;
  logic        d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] d_adr_i = '0, d_dat_i = '0;
  logic [31:0] d_dat_o;
  logic        d_ack_o;
  logic        c_stb_o, c_we_o;
  logic [31:0] c_adr_o, c_dat_o;
  logic [31:0] c_dat_i = '0;
  logic        c_ack_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  dcache_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p_req_i(p_req_i), .p_we_i(p_we_i), .p_adr_i(p_adr_i), .p_dat_i(p_dat_i),
    .p_dat_o(p_dat_o), .p_ack_o(p_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
    .c_stb_o(c_stb_o), .c_we_o(c_we_o), .c_adr_o(c_adr_o), .c_dat_o(c_dat_o),
    .c_dat_i(c_dat_i), .c_ack_i(c_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then settle so registered outputs are stable.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Cache responder: wait (bounded) for the strobe, hold off `delay` cycles,
  // then ack for one cycle. Returns just after the edge that enters DONE.
  task automatic cache_respond(input int delay, input logic [31:0] rdata);
    int waited;
    waited = 0;
    while (c_stb_o !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check_output("stb_wait", {31'd0, c_stb_o}, 32'd1);
    repeat (delay) tick();
    c_ack_i = 1'b1;
    c_dat_i = rdata;
    tick();
    c_ack_i = 1'b0;
  endtask

  logic exp_d [0:4];

  initial begin
    $display("[TB] starting dcache_arbiter bench");

    // Reset state
    apply_reset();
    check_output("rst_stb",   {31'd0, c_stb_o}, 32'd0);
    check_output("rst_we",    {31'd0, c_we_o},  32'd0);
    check_output("rst_pack",  {31'd0, p_ack_o}, 32'd0);
    check_output("rst_dack",  {31'd0, d_ack_o}, 32'd0);
    check_output("rst_cadr",  c_adr_o, 32'd0);
    check_output("rst_cdat",  c_dat_o, 32'd0);
    check_output("rst_pdat",  p_dat_o, 32'd0);
    check_output("rst_ddat",  d_dat_o, 32'd0);

    // P load at 0x100, cache acks two cycles after strobe
    p_req_i = 1'b1; p_we_i = 1'b0; p_adr_i = 32'h100; p_dat_i = 32'h0;
    tick();
    check_output("p_ld_stb",  {31'd0, c_stb_o}, 32'd1);
    check_output("p_ld_adr",  c_adr_o, 32'h100);
    check_output("p_ld_we",   {31'd0, c_we_o}, 32'd0);
    p_adr_i = 32'h999;
    tick();
    check_output("p_ld_hold", c_adr_o, 32'h100);
    check_output("p_ld_pack0", {31'd0, p_ack_o}, 32'd0);
    tick();
    c_ack_i = 1'b1; c_dat_i = 32'hDEADBEEF;
    tick();
    c_ack_i = 1'b0;
    check_output("p_ld_ack",  {31'd0, p_ack_o}, 32'd1);
    check_output("p_ld_data", p_dat_o, 32'hDEADBEEF);
    check_output("p_ld_dack", {31'd0, d_ack_o}, 32'd0);
    check_output("p_ld_stb0", {31'd0, c_stb_o}, 32'd0);
    p_req_i = 1'b0;
    tick();
    check_output("p_ld_pulse", {31'd0, p_ack_o}, 32'd0);

    // Simultaneous P and D from reset: P first, D granted right after DONE
    apply_reset();
    p_req_i = 1'b1; p_adr_i = 32'h300;
    d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = 32'h400;
    tick();
    check_output("both_first", c_adr_o, 32'h300);
    cache_respond(1, 32'hAAAA0001);
    check_output("both_pack",  {31'd0, p_ack_o}, 32'd1);
    check_output("both_dack0", {31'd0, d_ack_o}, 32'd0);
    p_req_i = 1'b0;
    tick();
    check_output("both_idle_stb", {31'd0, c_stb_o}, 32'd0);
    tick();
    check_output("both_second", c_adr_o, 32'h400);
    check_output("both_stb2",   {31'd0, c_stb_o}, 32'd1);
    cache_respond(0, 32'hBBBB0002);
    check_output("both_dack",  {31'd0, d_ack_o}, 32'd1);
    check_output("both_ddat",  d_dat_o, 32'hBBBB0002);
    check_output("both_pack0", {31'd0, p_ack_o}, 32'd0);
    d_req_i = 1'b0;
    tick();

    // Continuous contention: starvation release or round-robin alternation
`ifdef DCACHE_ARB_RR_EN
    exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b1; exp_d[4] = 1'b0;
`else
    exp_d[0] = 1'b0; exp_d[1] = 1'b0; exp_d[2] = 1'b0; exp_d[3] = 1'b1; exp_d[4] = 1'b0;
`endif
    apply_reset();
    p_req_i = 1'b1; p_adr_i = 32'h500;
    d_req_i = 1'b1; d_adr_i = 32'h600;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output($sformatf("cont_grant%0d", i), c_adr_o,
                   exp_d[i] ? 32'h600 : 32'h500);
      cache_respond(1, 32'hA0000000 + 32'(i));
      check_output($sformatf("cont_pack%0d", i), {31'd0, p_ack_o}, {31'd0, ~exp_d[i]});
      check_output($sformatf("cont_dack%0d", i), {31'd0, d_ack_o}, {31'd0, exp_d[i]});
      tick();
    end
    p_req_i = 1'b0; d_req_i = 1'b0;

    // Reset while BUSY, stray cache ack afterwards
    apply_reset();
    p_req_i = 1'b1; p_adr_i = 32'h700;
    tick();
    check_output("abort_stb1", {31'd0, c_stb_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; p_req_i = 1'b0;
    check_output("abort_stb0", {31'd0, c_stb_o}, 32'd0);
    c_ack_i = 1'b1; c_dat_i = 32'h55555555;
    tick();
    c_ack_i = 1'b0;
    check_output("abort_pack", {31'd0, p_ack_o}, 32'd0);
    check_output("abort_dack", {31'd0, d_ack_o}, 32'd0);
    check_output("abort_stb",  {31'd0, c_stb_o}, 32'd0);
    check_output("abort_pdat", p_dat_o, 32'd0);

    // D store with same-cycle ack; ack left high through DONE is ignored
    d_req_i = 1'b1; d_we_i = 1'b1; d_adr_i = 32'h200; d_dat_i = 32'h12345678;
    tick();
    check_output("dst_stb", {31'd0, c_stb_o}, 32'd1);
    check_output("dst_we",  {31'd0, c_we_o},  32'd1);
    check_output("dst_adr", c_adr_o, 32'h200);
    check_output("dst_dat", c_dat_o, 32'h12345678);
    c_ack_i = 1'b1; c_dat_i = 32'hCAFEF00D;
    tick();
    check_output("dst_dack", {31'd0, d_ack_o}, 32'd1);
    check_output("dst_pack", {31'd0, p_ack_o}, 32'd0);
    check_output("dst_ddat", d_dat_o, 32'hCAFEF00D);
    d_req_i = 1'b0;
    tick();
    c_ack_i = 1'b0;
    check_output("dst_pulse", {31'd0, d_ack_o}, 32'd0);
    check_output("dst_stb0",  {31'd0, c_stb_o}, 32'd0);
    tick();
    check_output("dst_idle_dack", {31'd0, d_ack_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_dcache_arbiter

// File: doc/dcache_arbiter.md
DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: max consecutive pipeline grants while debug waits (range 1..255).
REQ-002 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port p_req_i, input, 1: pipeline (writeback stage) access request, level, held until p_ack_o.
REQ-005 SHALL have port p_we_i, input, 1: pipeline write enable (1 = store).
REQ-006 SHALL have port p_adr_i, input, 32: pipeline byte address.
REQ-007 SHALL have port p_dat_i, input, 32: pipeline store data.
REQ-008 SHALL have port p_dat_o, output, 32: pipeline load data, valid while p_ack_o is high.
REQ-009 SHALL have port p_ack_o, output, 1: one-cycle pipeline completion pulse.
REQ-010 SHALL have port d_req_i, input, 1: debug/DMA access request, level, held until d_ack_o.
REQ-011 SHALL have port d_we_i, input, 1: debug write enable.
REQ-012 SHALL have port d_adr_i, input, 32: debug byte address.
REQ-013 SHALL have port d_dat_i, input, 32: debug store data.
REQ-014 SHALL have port d_dat_o, output, 32: debug load data, valid while d_ack_o is high.
REQ-015 SHALL have port d_ack_o, output, 1: one-cycle debug completion pulse.
REQ-016 SHALL have port c_stb_o, output, 1: cache access strobe, held until c_ack_i.
REQ-017 SHALL have port c_we_o, output, 1: cache write enable.
REQ-018 SHALL have port c_adr_o, output, 32: cache address.
REQ-019 SHALL have port c_dat_o, output, 32: cache write data.
REQ-020 SHALL have port c_dat_i, input, 32: cache read data, valid with c_ack_i.
REQ-021 SHALL have port c_ack_i, input, 1: cache completion; may be high in the same cycle stb first rises or many cycles later.

Function
REQ-022 SHALL implement FSM IDLE -> BUSY (owner = P or D) -> DONE -> IDLE.
REQ-023 IDLE: if any req high, SHALL latch winner's we/adr/dat into c_*_o and assert c_stb_o from the next cycle (1-cycle request-to-strobe latency).
REQ-024 Fixed priority: P over D when both request, except D SHALL win when starvation counter == STARVE_LIMIT.
REQ-025 Starvation counter (8-bit) SHALL increment on each P grant while d_req_i high, clear on any D grant, saturate at STARVE_LIMIT.
REQ-026 BUSY: c_stb_o/c_we_o/c_adr_o/c_dat_o SHALL stay constant; request input changes ignored.
REQ-027 On c_ack_i in BUSY: SHALL drop c_stb_o next cycle, register c_dat_i into owner's dat_o, pulse owner's ack_o for exactly one cycle (DONE state).
REQ-028 DONE: SHALL ignore all requests (requester drops req same cycle it sees ack); next state IDLE; minimum access period 3 cycles.
REQ-029 c_ack_i in IDLE or DONE SHALL be ignored; non-owner ack_o SHALL never assert.
REQ-030 Store accesses SHALL still return c_dat_i on dat_o (don't-care contents) and ack normally.

Reset
REQ-031 With rst_i high at an edge: state IDLE, counter 0, RR pointer to P, c_stb_o/c_we_o/p_ack_o/d_ack_o 0, all 32-bit outputs 0.
REQ-032 Reset mid-access SHALL abort it with no ack pulse; a later stray c_ack_i SHALL be ignored.

Configuration
REQ-033 Macro DCACHE_ARB_RR_EN defined: round-robin; on simultaneous requests SHALL grant the port not granted last; starvation counter and STARVE_LIMIT unused.
REQ-034 Macro undefined: fixed priority with starvation counter per REQ-024/025.

Structure
REQ-035 Package dcache_arb_pkg SHALL hold the FSM state typedef, the owner encoding (P/D) and the STARVE_LIMIT default constant.
REQ-036 No sub-module; winner selection is a combinational function inside dcache_arbiter.

Verification
REQ-037 P load adr 0x100, cache acks 2 cycles after stb, c_dat_i 0xDEADBEEF -> p_ack_o one cycle, p_dat_o 0xDEADBEEF, d_ack_o stays 0.
REQ-038 P and D request together in IDLE (fixed priority) -> P served first, D served immediately after P's DONE.
REQ-039 P requests continuously while D waits, STARVE_LIMIT=3 -> D granted after exactly 3 P grants, counter clears.
REQ-040 DCACHE_ARB_RR_EN, both requesting continuously -> grants alternate P, D, P, D.
REQ-041 rst_i pulsed while BUSY with c_ack_i 1 cycle later -> no ack pulse, c_stb_o 0, FSM idle.
REQ-042 c_ack_i same cycle stb rises, D store 0x12345678 to 0x200 -> c_we_o 1, c_dat_o 0x12345678, d_ack_o next cycle.
